// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard detection and operand forwarding, plus the
//               occupancy tracker for the iterative mult/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [4:0] rs_E,
   input  logic [4:0] rt_E,
   input  logic [4:0] reg_id_E,
   input  logic [4:0] reg_id_M,
   input  logic [4:0] reg_id_W,
   input  logic       reg_write_E,
   input  logic       reg_write_M,
   input  logic       reg_write_W,
   input  logic       mem_to_reg_E,
   input  logic       mem_to_reg_M,
   input  logic       branch_D,
   input  logic       md_op_D,
   input  logic       mfhilo_D,
   input  logic       md_start_E,
   input  logic       md_is_div_E,
   output logic       stall_F,
   output logic       stall_D,
   output logic       flush_E,
   output logic       forwardA_D,
   output logic       forwardB_D,
   output logic [1:0] forwardA_E,
   output logic [1:0] forwardB_E,
   output logic       md_busy,
   output logic       md_done
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   localparam logic [5:0] c_MUL_LOAD = 6'(MUL_LAT - 1);
   localparam logic [5:0] c_DIV_LOAD = 6'(DIV_LAT - 1);

   md_state_t  r_state;
   md_state_t  w_state_nxt;
   logic [5:0] r_cnt;
   logic [5:0] w_cnt_nxt;
   logic       w_lwstall;
   logic       w_brstall;
   logic       w_mdstall;
   logic       w_stall;

   // Register 0 is hardwired to zero, so it never creates a dependency.
   function automatic logic f_match(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 6'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A start seen while busy is dropped; decode stalls keep that from happening.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (md_start_E) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = md_is_div_E ? c_DIV_LOAD : c_MUL_LOAD;
            end
         end
         ST_BUSY: begin
            if (r_cnt != 6'd0) begin
               w_cnt_nxt = r_cnt - 6'd1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign md_busy = (r_state == ST_BUSY);
   assign md_done = (r_state == ST_BUSY) && (r_cnt == 6'd0);

   always_comb begin
      forwardA_E = 2'b00;
      forwardB_E = 2'b00;
      if (reg_write_M && f_match(rs_E, reg_id_M)) begin
         forwardA_E = 2'b10;
      end else if (reg_write_W && f_match(rs_E, reg_id_W)) begin
         forwardA_E = 2'b01;
      end
      if (reg_write_M && f_match(rt_E, reg_id_M)) begin
         forwardB_E = 2'b10;
      end else if (reg_write_W && f_match(rt_E, reg_id_W)) begin
         forwardB_E = 2'b01;
      end
   end

   assign forwardA_D = reg_write_M && f_match(rs_D, reg_id_M);
   assign forwardB_D = reg_write_M && f_match(rt_D, reg_id_M);

   assign w_lwstall = mem_to_reg_E && (f_match(rt_E, rs_D) || f_match(rt_E, rt_D));
   assign w_brstall = branch_D &&
                      ((reg_write_E  && (f_match(reg_id_E, rs_D) || f_match(reg_id_E, rt_D))) ||
                       (mem_to_reg_M && (f_match(reg_id_M, rs_D) || f_match(reg_id_M, rt_D))));
   // While reset is asserted the busy state is already being discarded.
   assign w_mdstall = (md_op_D || mfhilo_D) &&
                      (((r_state == ST_BUSY) && !reset) || md_start_E);
   assign w_stall   = w_lwstall || w_brstall || w_mdstall;

   assign stall_F = w_stall;
   assign stall_D = w_stall;
   assign flush_E = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: vector table, directed
//               mult/div sequences and randomized run against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int c_MUL_LAT = 4;
   localparam int c_DIV_LAT = 32;

   typedef struct {
      logic [4:0] rs_d, rt_d, rs_e, rt_e, id_e, id_m, id_w;
      logic       we_e, we_m, we_w, m2r_e, m2r_m, br, mdop, mfhl, mds, mdiv;
      logic       e_stall;
      logic [1:0] e_fae, e_fbe;
      logic       e_fad, e_fbd;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, rs_E, rt_E, reg_id_E, reg_id_M, reg_id_W;
   logic       reg_write_E, reg_write_M, reg_write_W, mem_to_reg_E, mem_to_reg_M;
   logic       branch_D, md_op_D, mfhilo_D, md_start_E, md_is_div_E;
   logic       stall_F, stall_D, flush_E, forwardA_D, forwardB_D, md_busy, md_done;
   logic [1:0] forwardA_E, forwardB_E;

   int n_chk  = 0;
   int n_fail = 0;

   hazard_ctrl #(.MUL_LAT(c_MUL_LAT), .DIV_LAT(c_DIV_LAT)) dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
      .reg_id_E(reg_id_E), .reg_id_M(reg_id_M), .reg_id_W(reg_id_W),
      .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
      .mem_to_reg_E(mem_to_reg_E), .mem_to_reg_M(mem_to_reg_M),
      .branch_D(branch_D), .md_op_D(md_op_D), .mfhilo_D(mfhilo_D),
      .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
      .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
      .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
      .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
      .md_busy(md_busy), .md_done(md_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b, expected %0b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      rs_D = v.rs_d;  rt_D = v.rt_d;  rs_E = v.rs_e;  rt_E = v.rt_e;
      reg_id_E = v.id_e;  reg_id_M = v.id_m;  reg_id_W = v.id_w;
      reg_write_E = v.we_e;  reg_write_M = v.we_m;  reg_write_W = v.we_w;
      mem_to_reg_E = v.m2r_e;  mem_to_reg_M = v.m2r_m;
      branch_D = v.br;  md_op_D = v.mdop;  mfhilo_D = v.mfhl;
      md_start_E = v.mds;  md_is_div_E = v.mdiv;
   endtask

   task automatic check_comb(input vec_t v);
      chk({v.name, "/stall"}, {1'b0, stall_F, stall_D, flush_E}, {1'b0, {3{v.e_stall}}});
      chk({v.name, "/fwdA_E"}, {2'b00, forwardA_E}, {2'b00, v.e_fae});
      chk({v.name, "/fwdB_E"}, {2'b00, forwardB_E}, {2'b00, v.e_fbe});
      chk({v.name, "/fwdA_D"}, {3'b000, forwardA_D}, {3'b000, v.e_fad});
      chk({v.name, "/fwdB_D"}, {3'b000, forwardB_D}, {3'b000, v.e_fbd});
   endtask

   // Expected combinational outputs straight from the hazard rules.
   function automatic vec_t ref_comb(input vec_t v, input bit unit_busy, input bit rst);
      vec_t r = v;
      bit lw, brs, mds;
      r.e_fae = (v.we_m && v.rs_e != 0 && v.rs_e == v.id_m) ? 2'b10 :
                (v.we_w && v.rs_e != 0 && v.rs_e == v.id_w) ? 2'b01 : 2'b00;
      r.e_fbe = (v.we_m && v.rt_e != 0 && v.rt_e == v.id_m) ? 2'b10 :
                (v.we_w && v.rt_e != 0 && v.rt_e == v.id_w) ? 2'b01 : 2'b00;
      r.e_fad = v.we_m && v.rs_d != 0 && v.rs_d == v.id_m;
      r.e_fbd = v.we_m && v.rt_d != 0 && v.rt_d == v.id_m;
      lw  = v.m2r_e && v.rt_e != 0 && (v.rt_e == v.rs_d || v.rt_e == v.rt_d);
      brs = v.br && ((v.we_e && v.id_e != 0 && (v.id_e == v.rs_d || v.id_e == v.rt_d)) ||
                     (v.m2r_m && v.id_m != 0 && (v.id_m == v.rs_d || v.id_m == v.rt_d)));
      mds = (v.mdop || v.mfhl) && ((unit_busy && !rst) || v.mds);
      r.e_stall = lw || brs || mds;
      return r;
   endfunction

   // Check md_busy/md_done/stall at the falling edge, then advance one cycle.
   task automatic md_step(input string nm, input bit eb, input bit ed, input bit es);
      @(negedge clk);
      chk({nm, "/busy"}, {3'b000, md_busy}, {3'b000, eb});
      chk({nm, "/done"}, {3'b000, md_done}, {3'b000, ed});
      chk({nm, "/stall"}, {1'b0, stall_F, stall_D, flush_E}, {1'b0, {3{es}}});
      @(posedge clk); #1;
   endtask

   vec_t quiet, v, tbl[$];

   initial begin
      quiet = '{rs_d:0, rt_d:0, rs_e:0, rt_e:0, id_e:0, id_m:0, id_w:0,
                we_e:0, we_m:0, we_w:0, m2r_e:0, m2r_m:0, br:0, mdop:0, mfhl:0,
                mds:0, mdiv:0, e_stall:0, e_fae:0, e_fbe:0, e_fad:0, e_fbd:0, name:"quiet"};
      drive(quiet);
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset/busy", {3'b000, md_busy}, 4'b0000);
      chk("reset/done", {3'b000, md_done}, 4'b0000);
      @(posedge clk); #1;
      reset = 1'b0;

      v = quiet; v.rs_e = 5; v.id_m = 5; v.we_m = 1; v.id_w = 5; v.we_w = 1;
      v.e_fae = 2'b10; v.name = "fwd_m_prio"; tbl.push_back(v);
      v.we_m = 0; v.e_fae = 2'b01; v.name = "fwd_w"; tbl.push_back(v);
      v.rs_e = 0; v.e_fae = 2'b00; v.name = "fwd_rs0"; tbl.push_back(v);
      v = quiet; v.id_m = 0; v.we_m = 1; v.id_w = 0; v.we_w = 1; v.name = "fwd_r0_all"; tbl.push_back(v);
      v = quiet; v.rt_e = 7; v.id_w = 7; v.we_w = 1; v.id_m = 7;
      v.e_fbe = 2'b01; v.name = "fwdB_w"; tbl.push_back(v);
      v = quiet; v.m2r_e = 1; v.rt_e = 8; v.rs_d = 8; v.e_stall = 1; v.name = "lduse_rs"; tbl.push_back(v);
      v.rt_e = 9; v.e_stall = 0; v.name = "lduse_clear"; tbl.push_back(v);
      v = quiet; v.m2r_e = 1; v.rt_e = 12; v.rt_d = 12; v.e_stall = 1; v.name = "lduse_rt"; tbl.push_back(v);
      v = quiet; v.m2r_e = 1; v.name = "lduse_r0"; tbl.push_back(v);
      v = quiet; v.br = 1; v.we_e = 1; v.id_e = 3; v.rt_d = 3; v.e_stall = 1; v.name = "br_e"; tbl.push_back(v);
      v.we_e = 0; v.id_m = 3; v.we_m = 1; v.e_stall = 0; v.e_fbd = 1; v.name = "br_fwd_m"; tbl.push_back(v);
      v = quiet; v.br = 1; v.id_m = 3; v.we_m = 1; v.m2r_m = 1; v.rs_d = 3;
      v.e_stall = 1; v.e_fad = 1; v.name = "br_load_m"; tbl.push_back(v);
      v = quiet; v.we_e = 1; v.id_e = 3; v.rt_d = 3; v.name = "no_branch"; tbl.push_back(v);
      v = quiet; v.mdop = 1; v.mfhl = 1; v.name = "md_idle"; tbl.push_back(v);
      v = quiet; v.mdop = 1; v.mds = 1; v.e_stall = 1; v.name = "md_b2b"; tbl.push_back(v);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         @(negedge clk);
         check_comb(tbl[i]);
         @(posedge clk); #1;
      end

      // Last vector started a multiply; clear it.
      drive(quiet);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Multiply latency with mfhilo held
      md_start_E = 1; mfhilo_D = 1;
      md_step("mul_c0", 0, 0, 1);
      md_start_E = 0;
      for (int c = 1; c <= c_MUL_LAT; c++) md_step($sformatf("mul_c%0d", c), 1, c == c_MUL_LAT, 1);
      md_step("mul_c5", 0, 0, 0);
      mfhilo_D = 0;

      // Start pulse during busy is ignored
      md_start_E = 1;
      md_step("ign_c0", 0, 0, 0);
      md_start_E = 0;
      md_step("ign_c1", 1, 0, 0);
      md_start_E = 1;
      md_step("ign_c2", 1, 0, 0);
      md_start_E = 0;
      md_step("ign_c3", 1, 0, 0);
      md_step("ign_c4", 1, 1, 0);
      for (int c = 5; c <= 8; c++) md_step($sformatf("ign_c%0d", c), 0, 0, 0);

      // Divide aborted by reset
      md_start_E = 1; md_is_div_E = 1;
      md_step("div_c0", 0, 0, 0);
      md_start_E = 0; md_is_div_E = 0;
      for (int c = 1; c <= 9; c++) md_step($sformatf("div_c%0d", c), 1, 0, 0);
      reset = 1; mfhilo_D = 1;
      md_step("div_c10", 1, 0, 0);
      reset = 0; mfhilo_D = 0;
      for (int c = 11; c <= 40; c++) md_step($sformatf("div_c%0d", c), 0, 0, 0);

      // Randomized run against a cycle-count model of the unit
      begin
         int  op_end = -1;
         bit  ubusy;
         bit  rst;
         vec_t e;
         for (int c = 0; c < 3000; c++) begin
            v = quiet;
            v.rs_d = 5'($urandom_range(0, 3)); v.rt_d = 5'($urandom_range(0, 3));
            v.rs_e = 5'($urandom_range(0, 3)); v.rt_e = 5'($urandom_range(0, 3));
            v.id_e = 5'($urandom_range(0, 3)); v.id_m = 5'($urandom_range(0, 3));
            v.id_w = 5'($urandom_range(0, 3));
            v.we_e = 1'($urandom); v.we_m = 1'($urandom); v.we_w = 1'($urandom);
            v.m2r_e = 1'($urandom); v.m2r_m = 1'($urandom); v.br = 1'($urandom);
            v.mdop = ($urandom_range(0, 3) == 0); v.mfhl = ($urandom_range(0, 3) == 0);
            v.mds = ($urandom_range(0, 3) == 0); v.mdiv = ($urandom_range(0, 3) == 0);
            v.name = "rnd";
            rst = ($urandom_range(0, 99) == 0);
            reset = rst;
            drive(v);
            ubusy = (c <= op_end);
            e = ref_comb(v, ubusy, rst);
            @(negedge clk);
            check_comb(e);
            chk("rnd/busy", {3'b000, md_busy}, {3'b000, ubusy});
            chk("rnd/done", {3'b000, md_done}, {3'b000, (c == op_end)});
            if (rst) op_end = c;
            else if (v.mds && !ubusy) op_end = c + (v.mdiv ? c_DIV_LAT : c_MUL_LAT);
            @(posedge clk); #1;
         end
         reset = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: multiply occupancy in cycles; legal range 2..63.
REQ-002 Parameter DIV_LAT, default 32: divide occupancy in cycles; legal range 2..63.
REQ-003 clk  in  1  clock; all state changes occur on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rs_D, rt_D  in  5 each  decode-stage source register ids.
REQ-006 rs_E, rt_E  in  5 each  execute-stage source register ids.
REQ-007 reg_id_E, reg_id_M, reg_id_W  in  5 each  destination register ids per stage.
REQ-008 reg_write_E, reg_write_M, reg_write_W  in  1 each  stage writes the register file.
REQ-009 mem_to_reg_E, mem_to_reg_M  in  1 each  stage holds a load.
REQ-010 branch_D  in  1  decode-stage instruction is a conditional branch.
REQ-011 md_op_D  in  1  decode-stage instruction is a mult/div.
REQ-012 mfhilo_D  in  1  decode-stage instruction reads HI/LO.
REQ-013 md_start_E, md_is_div_E  in  1 each  mult/div issues in E; 1 = divide.
REQ-014 stall_F, stall_D, flush_E  out  1 each  pipeline hold/bubble controls.
REQ-015 forwardA_D, forwardB_D  out  1 each  select alu_out_M for the branch comparator.
REQ-016 forwardA_E, forwardB_E  out  2 each  ALU operand source: 00 regfile, 01 result_W, 10 alu_out_M.
REQ-017 md_busy, md_done  out  1 each  mult/div unit occupied; one-cycle completion pulse.

Function
REQ-018 Register id 0 SHALL never match for any forwarding or hazard comparison.
REQ-019 forwardA_E SHALL be 10 if rs_E==reg_id_M and reg_write_M; else 01 if rs_E==reg_id_W and reg_write_W; else 00. forwardB_E is identical using rt_E. M has priority over W.
REQ-020 forwardA_D SHALL be 1 iff rs_D==reg_id_M and reg_write_M; forwardB_D likewise using rt_D.
REQ-021 lwstall = mem_to_reg_E and (rt_E==rs_D or rt_E==rt_D).
REQ-022 brstall = branch_D and ((reg_write_E and reg_id_E matches rs_D or rt_D) or (mem_to_reg_M and reg_id_M matches rs_D or rt_D)).
REQ-023 mdstall = (md_op_D or mfhilo_D) and (state==BUSY or md_start_E).
REQ-024 stall_F = stall_D = flush_E = lwstall or brstall or mdstall. All hazard and forwarding outputs are combinational, with no added latency.
REQ-025 The FSM SHALL have two states, IDLE and BUSY, and a 6-bit down-counter cnt.
REQ-026 In IDLE, if md_start_E: load cnt with (md_is_div_E ? DIV_LAT : MUL_LAT) - 1 and go to BUSY; otherwise stay in IDLE.
REQ-027 In BUSY with cnt != 0: decrement cnt. In BUSY with cnt == 0: go to IDLE.
REQ-028 md_busy = (state==BUSY); md_done = (state==BUSY and cnt==0).
REQ-029 Latency: for md_start_E sampled in cycle 0, md_busy is high in cycles 1..LAT, md_done is high only in cycle LAT, and the state is IDLE in cycle LAT+1.
REQ-030 md_start_E while in BUSY SHALL be ignored, with no state or count change (protocol error; REQ-023 prevents it).
REQ-031 md_start_E and md_op_D in the same IDLE cycle SHALL stall D, so back-to-back mult/div ops serialize.
REQ-032 flush_E does not cancel an operation already accepted into BUSY.

Reset
REQ-033 When reset is sampled high: state = IDLE, cnt = 0, md_busy = 0, md_done = 0.
REQ-034 Reset in BUSY aborts the operation; md_done SHALL NOT assert for it.
REQ-035 During reset, the combinational outputs still follow their inputs, except that mdstall only sees md_start_E.

Verification
REQ-036 Forwarding: rs_E=5, reg_id_M=5, reg_write_M=1, reg_id_W=5, reg_write_W=1 -> forwardA_E=10. Clear reg_write_M -> 01. Set rs_E=0 -> 00.
REQ-037 Load-use: mem_to_reg_E=1, rt_E=8, rs_D=8 -> stall_F=stall_D=flush_E=1. Change rt_E to 9 -> all 0.
REQ-038 Branch: branch_D=1, reg_write_E=1, reg_id_E=3, rt_D=3 -> stall. Then reg_id_M=3, reg_write_M=1, mem_to_reg_M=0 -> no stall and forwardB_D=1.
REQ-039 Multiply: md_start_E in cycle 0, MUL_LAT=4 -> md_busy in cycles 1-4, md_done only in cycle 4. mfhilo_D held in cycles 0-4 -> stall in cycles 0-4, released in cycle 5.
REQ-040 Divide with reset: md_start_E, md_is_div_E=1 in cycle 0; reset in cycle 10 -> md_busy=0 from cycle 11 and md_done is never asserted.
REQ-041 Ignore check: md_start_E pulsed in cycle 2 of an active multiply -> completion stays at cycle 4 and no second operation starts.
